// File: rtl/analog_switch_seq.sv
// Shadow registers plus break-before-make sequencer for analog_switch_sel.
// Commit opens all loops, waits, updates pull-up/down and termination, waits, then closes the new loops.
module analog_switch_seq #(
  parameter int BREAK_CYC = 100,
  parameter int MAKE_CYC  = 100,
  parameter int CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_en_i,
  input  logic [1:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [1:0] rd_addr_i,
  output logic [7:0] rd_data_o,
  output logic [3:0] pud_sel_o,
  output logic [2:0] tr_sel_o,
  output logic [3:0] lp_sel_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic       pending, pending_next, busy_next;
  logic [CNT_W-1:0] cnt;
  logic       cnt_zero, commit, start, apply_pt, apply_lp;

  logic [3:0] shadow_pud, snap_pud;
  logic [2:0] shadow_tr,  snap_tr;
  logic [3:0] shadow_lp,  snap_lp;

  // Upper data bits carry no function for any register.
  logic unused_wr_bits;
  assign unused_wr_bits = ^wr_data_i[7:4];

  assign commit   = wr_en_i && (wr_addr_i == 2'd3) && wr_data_i[0];
  assign cnt_zero = (cnt == '0);

  // State register.
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: each combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (commit || pending) state_next = ST_BREAK;
      ST_BREAK:  if (cnt_zero)          state_next = ST_SETTLE;
      ST_SETTLE: if (cnt_zero)          state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  // Control strobes; a commit arriving mid-sequence is parked in pending.
  always_comb begin
    start        = (state == ST_IDLE) && (commit || pending);
    apply_pt     = (state == ST_BREAK) && cnt_zero;
    apply_lp     = (state == ST_SETTLE) && cnt_zero;
    pending_next = (state != ST_IDLE) ? (pending || commit) : 1'b0;
    busy_next    = (state_next != ST_IDLE) || pending_next;
  end

  // Datapath: shadows, snapshot, applied selects, counter, readback.
  // NOTE: shadows and snapshot are plain registers (not a RAM), so they are
  // cleared by reset together with the applied outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_pud <= '0;
      shadow_tr  <= '0;
      shadow_lp  <= '0;
      snap_pud   <= '0;
      snap_tr    <= '0;
      snap_lp    <= '0;
      pud_sel_o  <= '0;
      tr_sel_o   <= '0;
      lp_sel_o   <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      pending <= pending_next;
      busy_o  <= busy_next;
      done_o  <= apply_lp;

      if (wr_en_i) begin
        case (wr_addr_i)
          2'd0:    shadow_pud <= wr_data_i[3:0];
          2'd1:    shadow_tr  <= wr_data_i[2:0];
          2'd2:    shadow_lp  <= wr_data_i[3:0];
          default: ;
        endcase
      end

      if (start) begin
        snap_pud <= shadow_pud;
        snap_tr  <= shadow_tr;
        snap_lp  <= shadow_lp;
        lp_sel_o <= '0;
        cnt      <= CNT_W'(BREAK_CYC - 1);
      end else if (apply_pt) begin
        pud_sel_o <= snap_pud;
        tr_sel_o  <= snap_tr;
        cnt       <= CNT_W'(MAKE_CYC - 1);
      end else if (apply_lp) begin
        lp_sel_o <= snap_lp;
      end else if (!cnt_zero) begin
        cnt <= cnt - CNT_W'(1);
      end

      // Readback sees pre-edge values, so a same-cycle write returns old data.
      case (rd_addr_i)
        2'd0:    rd_data_o <= {4'b0, shadow_pud};
        2'd1:    rd_data_o <= {5'b0, shadow_tr};
        2'd2:    rd_data_o <= {4'b0, shadow_lp};
        default: rd_data_o <= {6'b0, pending, busy_o};
      endcase
    end
  end

endmodule

// File: tb/tb_analog_switch_seq.sv
// Self-checking bench for analog_switch_seq with BREAK_CYC=4, MAKE_CYC=3.
// A scoreboard queue holds the selects each sequence must apply when done_o pulses.
module tb_analog_switch_seq;

  localparam int BREAK_CYC = 4;
  localparam int MAKE_CYC  = 3;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       wr_en_i = 1'b0;
  logic [1:0] wr_addr_i = '0;
  logic [7:0] wr_data_i = '0;
  logic [1:0] rd_addr_i = '0;
  logic [7:0] rd_data_o;
  logic [3:0] pud_sel_o;
  logic [2:0] tr_sel_o;
  logic [3:0] lp_sel_o;
  logic       busy_o;
  logic       done_o;

  analog_switch_seq #(
    .BREAK_CYC(BREAK_CYC),
    .MAKE_CYC (MAKE_CYC),
    .CNT_W    (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_en_i  (wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o),
    .pud_sel_o(pud_sel_o),
    .tr_sel_o (tr_sel_o),
    .lp_sel_o (lp_sel_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] pud;
    logic [2:0] tr;
    logic [3:0] lp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  logic       rst_seen = 1'b1;
  logic [3:0] prev_pud = '0;
  logic [2:0] prev_tr  = '0;
  logic [3:0] prev_lp  = '0;

  always @(posedge clk_i) rst_seen <= rst_i;

  // Scoreboard and break-before-make monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (done_o === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done_o=1, expected no sequence completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({pud_sel_o, tr_sel_o, lp_sel_o} !== {e.pud, e.tr, e.lp}) begin
          errors++;
          $display("FAIL sb_applied: got pud=%h tr=%h lp=%h, expected pud=%h tr=%h lp=%h",
                   pud_sel_o, tr_sel_o, lp_sel_o, e.pud, e.tr, e.lp);
        end
      end
    end
    if (!rst_seen && ((pud_sel_o !== prev_pud) || (tr_sel_o !== prev_tr))) begin
      checks++;
      if ((prev_lp !== 4'd0) || (lp_sel_o !== 4'd0)) begin
        errors++;
        $display("FAIL bbm_invariant: pud/tr changed with lp prev=%h now=%h, expected 0", prev_lp, lp_sel_o);
      end
    end
    prev_pud = pud_sel_o;
    prev_tr  = tr_sel_o;
    prev_lp  = lp_sel_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    step(1);
    wr_en_i   = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    step(3);
    rst_i = 1'b0;
    rd_addr_i = 2'd3;
    step(10);
    checks++; if (pud_sel_o !== 4'h0) begin errors++; $display("FAIL reset_pud: got %h expected 0", pud_sel_o); end
    checks++; if (tr_sel_o  !== 3'h0) begin errors++; $display("FAIL reset_tr: got %h expected 0", tr_sel_o); end
    checks++; if (lp_sel_o  !== 4'h0) begin errors++; $display("FAIL reset_lp: got %h expected 0", lp_sel_o); end
    checks++; if (busy_o    !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o    !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_rd_ctrl: got %h expected 00", rd_data_o); end
  endtask

  task automatic test_basic_commit;
    wr(2'd0, 8'h0A);
    wr(2'd1, 8'h05);
    wr(2'd2, 8'h0F);
    rd_addr_i = 2'd0;
    step(1);
    checks++; if (rd_data_o !== 8'h0A) begin errors++; $display("FAIL basic_rd_pud: got %h expected 0a", rd_data_o); end
    checks++; if (lp_sel_o !== 4'h0) begin errors++; $display("FAIL basic_shadow_only: got lp=%h expected 0", lp_sel_o); end
    exp_q.push_back('{pud: 4'hA, tr: 3'h5, lp: 4'hF});
    wr(2'd3, 8'h01);                                   // edge T
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy_T: got %b expected 1", busy_o); end
    step(BREAK_CYC - 1);                               // T+3
    checks++; if (pud_sel_o !== 4'h0) begin errors++; $display("FAIL basic_pud_early: got %h expected 0", pud_sel_o); end
    step(1);                                           // T+4
    checks++; if ({pud_sel_o, tr_sel_o, lp_sel_o} !== {4'hA, 3'h5, 4'h0}) begin
      errors++; $display("FAIL basic_pt_apply: got pud=%h tr=%h lp=%h expected a 5 0", pud_sel_o, tr_sel_o, lp_sel_o);
    end
    step(MAKE_CYC - 1);                                // T+6
    checks++; if ({lp_sel_o, done_o, busy_o} !== {4'h0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL basic_pre_make: got lp=%h done=%b busy=%b expected 0 0 1", lp_sel_o, done_o, busy_o);
    end
    step(1);                                           // T+7
    checks++; if ({lp_sel_o, done_o} !== {4'hF, 1'b1}) begin
      errors++; $display("FAIL basic_make: got lp=%h done=%b expected f 1", lp_sel_o, done_o);
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy_o); end
    step(1);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done_o); end
  endtask

  task automatic test_reapply;
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h01);
    exp_q.push_back('{pud: 4'h1, tr: 3'h5, lp: 4'h3});
    wr(2'd3, 8'h01);
    checks++; if ({lp_sel_o, pud_sel_o} !== {4'h0, 4'hA}) begin
      errors++; $display("FAIL reapply_break: got lp=%h pud=%h expected 0 a", lp_sel_o, pud_sel_o);
    end
    step(BREAK_CYC);
    checks++; if ({pud_sel_o, tr_sel_o, lp_sel_o} !== {4'h1, 3'h5, 4'h0}) begin
      errors++; $display("FAIL reapply_pt: got pud=%h tr=%h lp=%h expected 1 5 0", pud_sel_o, tr_sel_o, lp_sel_o);
    end
    step(MAKE_CYC);
    checks++; if ({lp_sel_o, done_o} !== {4'h3, 1'b1}) begin
      errors++; $display("FAIL reapply_make: got lp=%h done=%b expected 3 1", lp_sel_o, done_o);
    end
    step(2);
  endtask

  task automatic test_back_to_back;
    int base;
    base = done_cnt;
    wr(2'd0, 8'h02);
    exp_q.push_back('{pud: 4'h2, tr: 3'h5, lp: 4'h3});
    exp_q.push_back('{pud: 4'h6, tr: 3'h5, lp: 4'h3});
    rd_addr_i = 2'd3;
    wr(2'd3, 8'h01);                                   // T
    step(1);                                           // T+1
    wr(2'd0, 8'h06);                                   // T+2
    wr(2'd3, 8'h01);                                   // T+3
    wr(2'd3, 8'h01);                                   // T+4
    checks++; if (rd_data_o !== 8'h03) begin errors++; $display("FAIL b2b_rd_pending: got %h expected 03", rd_data_o); end
    for (int i = 0; i < 40 && done_cnt < base + 2; i++) step(1);
    checks++; if (done_cnt !== base + 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d pulses expected 2 within budget", done_cnt - base);
    end
    step(6);
    checks++; if (done_cnt !== base + 2) begin errors++; $display("FAIL b2b_extra_seq: got %0d pulses expected 2", done_cnt - base); end
    checks++; if ({busy_o, pud_sel_o} !== {1'b0, 4'h6}) begin
      errors++; $display("FAIL b2b_final: got busy=%b pud=%h expected 0 6", busy_o, pud_sel_o);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    base = done_cnt;
    wr(2'd2, 8'h09);
    wr(2'd0, 8'h04);
    wr(2'd3, 8'h01);                                   // T
    step(BREAK_CYC + 1);                               // in SETTLE, pud applied
    checks++; if ({pud_sel_o, lp_sel_o} !== {4'h4, 4'h0}) begin
      errors++; $display("FAIL mid_settle: got pud=%h lp=%h expected 4 0", pud_sel_o, lp_sel_o);
    end
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    checks++; if ({pud_sel_o, tr_sel_o, lp_sel_o, busy_o, done_o, rd_data_o} !== '0) begin
      errors++; $display("FAIL mid_reset: got pud=%h tr=%h lp=%h busy=%b done=%b rd=%h expected all 0",
                         pud_sel_o, tr_sel_o, lp_sel_o, busy_o, done_o, rd_data_o);
    end
    rd_addr_i = 2'd3;
    step(10);
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt - base); end
    checks++; if ({busy_o, rd_data_o} !== {1'b0, 8'h00}) begin
      errors++; $display("FAIL mid_idle: got busy=%b rd=%h expected 0 00", busy_o, rd_data_o);
    end
  endtask

  task automatic test_no_commit;
    int base;
    base = done_cnt;
    wr(2'd3, 8'hFE);
    wr(2'd1, 8'hFF);
    rd_addr_i = 2'd1;
    step(10);
    checks++; if ({busy_o, tr_sel_o, lp_sel_o} !== {1'b0, 3'h0, 4'h0}) begin
      errors++; $display("FAIL nocommit_outputs: got busy=%b tr=%h lp=%h expected 0 0 0", busy_o, tr_sel_o, lp_sel_o);
    end
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL nocommit_done: got %0d pulses expected 0", done_cnt - base); end
    checks++; if (rd_data_o !== 8'h07) begin errors++; $display("FAIL nocommit_rd_tr: got %h expected 07", rd_data_o); end
  endtask

  task automatic test_rw_same_cycle;
    rd_addr_i = 2'd0;
    wr(2'd0, 8'h0C);
    checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL rw_old_value: got %h expected 00", rd_data_o); end
    step(1);
    checks++; if (rd_data_o !== 8'h0C) begin errors++; $display("FAIL rw_new_value: got %h expected 0c", rd_data_o); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_reapply();
    test_back_to_back();
    test_reset_mid();
    test_no_commit();
    test_rw_same_cycle();
    step(2);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending entries expected 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
